// File: rtl/des_shared2.sv
// Flit deserializer with two selectable word lengths; flit k lands in slice k,
// the finished word is held in an output register behind a ready/valid handshake.
package des_shared2_pkg;
   function automatic int get_max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

module des_shared2
   import des_shared2_pkg::*;
#(
   parameter int SER_WIDTH = 15,
   parameter int COUNT_0   = 2,
   parameter int COUNT_1   = 1,
   localparam int COUNT_MAX = get_max2(COUNT_0, COUNT_1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           count_sel,
   input  logic [SER_WIDTH-1:0]           serial_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   output logic [SER_WIDTH*COUNT_MAX-1:0] parallel_out,
   output logic                           valid_out,
   input  logic                           ready_in,
   output logic [COUNT_MAX-1:0]           cnt_out
);

   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

   state_t                                state;
   logic [COUNT_MAX-1:0][SER_WIDTH-1:0]   data;
   logic [COUNT_MAX-1:0]                  cnt;
   logic [COUNT_MAX-1:0]                  cnt_rot;
   logic                                  sel_q;
   logic                                  accept;
   logic                                  consume;
   logic                                  cur_sel;
   logic                                  last;

   assign valid_out    = (state == FULL);
   assign ready_out    = (state == COLLECT) | ready_in;
   assign parallel_out = data;
   assign cnt_out      = cnt;

   always_comb begin
      accept  = valid_in & ready_out;
      consume = valid_out & ready_in;
      // The select of the word in progress comes straight from the input on flit 0.
      cur_sel = cnt[0] ? count_sel : sel_q;
      last    = cur_sel ? cnt[COUNT_1-1] : cnt[COUNT_0-1];
      cnt_rot = (cnt << 1) | (cnt >> (COUNT_MAX-1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= COLLECT;
         data  <= '0;
         cnt   <= COUNT_MAX'(1);
         sel_q <= 1'b0;
      end else begin
         if (accept) begin
            // Flit 0 also zeroes the other slices so short words read back zero-padded.
            for (int unsigned k = 0; k < COUNT_MAX; k++) begin
               if (cnt[k])
                  data[k] <= serial_in;
               else if (cnt[0])
                  data[k] <= '0;
            end
            if (cnt[0])
               sel_q <= count_sel;
            cnt <= last ? COUNT_MAX'(1) : cnt_rot;
         end
         if (accept && last)
            state <= FULL;
         else if (consume)
            state <= COLLECT;
      end
   end

endmodule

// File: tb/tb_des_shared2.sv
// Randomized scoreboard bench for des_shared2: words are modelled as a list of
// flits and an expected integer value; a monitor pops and compares on each consume.
module tb_des_shared2;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          count_sel = 1'b0;
   logic [W-1:0]  serial_in = '0;
   logic          valid_in = 1'b0;
   logic          ready_in;
   logic          ready_out;
   logic [2*W-1:0] parallel_out;
   logic          valid_out;
   logic [1:0]    cnt_out;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;
   logic [2*W-1:0] exp_q[$];

   des_shared2 #(.SER_WIDTH(W), .COUNT_0(2), .COUNT_1(1)) dut (
      .clk(clk), .rst(rst), .count_sel(count_sel), .serial_in(serial_in),
      .valid_in(valid_in), .ready_out(ready_out), .parallel_out(parallel_out),
      .valid_out(valid_out), .ready_in(ready_in), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
   initial begin
      ready_in = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = ($urandom % 3) != 0;
            default: ready_in = 1'b0;
         endcase
      end
   end

   // Sends one word; word length 2 for sel=0, 1 for sel=1.
   task automatic send_word(input logic s, input logic [W-1:0] f0, input logic [W-1:0] f1,
                            input int gap);
      int n;
      logic acc;
      n = s ? 1 : 2;
      for (int k = 0; k < n; k++) begin
         valid_in  = 1'b1;
         serial_in = (k == 0) ? f0 : f1;
         count_sel = (k == 0) ? s : logic'($urandom % 2);
         acc = 1'b0;
         for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            check("cnt_out", 32'(cnt_out), 32'(1 << k));
            acc = ready_out;
            @(posedge clk); #1;
         end
         if (!acc) begin
            check("accept_timeout", 32'(acc), 32'd1);
            valid_in = 1'b0;
            return;
         end
      end
      exp_q.push_back((n == 2) ? {f1, f0} : {{W{1'b0}}, f0});
      check("latency_valid", 32'(valid_out), 32'd1);
      check("cnt_after_last", 32'(cnt_out), 32'd1);
      if (gap > 0) begin
         valid_in = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t;
      valid_in = 1'b0;
      rdy_mode = 0;
      t = 0;
      while ((exp_q.size() != 0 || valid_out) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: compares every consumed word and checks hold / handshake rules.
   initial begin
      logic           prev_stall;
      logic [2*W-1:0] prev_data;
      logic [2*W-1:0] exp;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(valid_out), 32'd1);
               check("hold_data", 32'(parallel_out), 32'(prev_data));
            end
            check("ready_out", 32'(ready_out), 32'(!valid_out || ready_in));
            if (valid_out && ready_in) begin
               check("word_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  check("word", 32'(parallel_out), 32'(exp));
               end
            end
            prev_stall = valid_out && !ready_in;
            prev_data  = parallel_out;
         end
      end
   end

   initial begin
      logic acc;
      #12;
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_ready_out", 32'(ready_out), 32'd1);
      check("rst_parallel", 32'(parallel_out), 32'd0);
      check("rst_cnt_out", 32'(cnt_out), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed words, then backpressure with a flit waiting behind a full word.
      send_word(1'b0, 8'hA1, 8'hB2, 1);
      send_word(1'b1, 8'h5C, 8'h00, 1);
      rdy_mode = 2;
      @(posedge clk); #1;
      send_word(1'b0, 8'h11, 8'h22, 0);
      fork
         send_word(1'b1, 8'h33, 8'h00, 1);
         begin
            repeat (3) @(posedge clk);
            #2;
            rdy_mode = 0;
         end
      join
      drain();

      // Back-to-back alternating lengths with no downstream stall.
      for (int i = 0; i < 4; i++)
         send_word(logic'(i % 2), 8'(8'h40 + i), 8'(8'h80 + i), 0);
      drain();

      // Randomized traffic with random backpressure, then full rate.
      rdy_mode = 1;
      for (int i = 0; i < 200; i++)
         send_word(logic'($urandom % 2), 8'($urandom), 8'($urandom),
                   (($urandom % 4) == 0) ? int'($urandom % 3) : 0);
      rdy_mode = 0;
      for (int i = 0; i < 100; i++)
         send_word(logic'($urandom % 2), 8'($urandom), 8'($urandom), 0);
      drain();

      // Reset after flit 0 discards the partial word.
      valid_in  = 1'b1;
      serial_in = 8'h77;
      count_sel = 1'b0;
      @(negedge clk);
      acc = ready_out;
      check("rst_mid_accept", 32'(acc), 32'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      check("rst_mid_cnt", 32'(cnt_out), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_valid_out", 32'(valid_out), 32'd0);
      check("rst_mid_cnt_out", 32'(cnt_out), 32'd1);
      check("rst_mid_parallel", 32'(parallel_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      send_word(1'b0, 8'h10, 8'h20, 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_shared2.md
# des_shared2

Deserializer that reassembles a word from narrow flits, supporting two deserialization counts (COUNT_0, COUNT_1) selected per word by `count_sel`. It sits directly downstream of the shared-value serializer on a narrow NI/router link. Flit 0 lands in the least-significant slice, so a serializer–link–deserializer chain returns the original parallel word. The assembled word is held in an output register and presented with a ready/valid handshake.

## Interface
- SER_WIDTH, 15, width of one flit
- COUNT_0, 2, flits per word when `count_sel`=0 (≥1)
- COUNT_1, 1, flits per word when `count_sel`=1 (≥1)
- COUNT_MAX = max(COUNT_0, COUNT_1), derived localparam (via `get_max2`)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- count_sel  in  1  word length select; sampled with the first flit of each word
- serial_in  in  SER_WIDTH  input flit
- valid_in  in  1  flit valid
- ready_out  out  1  flit accepted when valid_in & ready_out
- parallel_out  out  SER_WIDTH*COUNT_MAX  assembled word; slice k = flit k
- valid_out  out  1  word valid
- ready_in  in  1  downstream ready
- cnt_out  out  COUNT_MAX  one-hot index of the slice the next accepted flit writes

## Operation
- State:
  - data register, COUNT_MAX slices
  - one-hot write pointer `cnt`
  - latched select `sel_q`
  - `full` flag
- States:
  - COLLECT (`full`=0)
  - FULL (`full`=1, valid_out=1)
- `ready_out = ~full | ready_in`. This combinational path from ready_in is intentional and allows back-to-back words.
- Flit accept (`valid_in & ready_out`):
  - Write serial_in into the slice selected by `cnt`.
  - If `cnt` is at bit 0: latch `sel_q <= count_sel`, and clear all other slices to 0 in the same cycle.
  - The word length of the current word is `count_sel` when `cnt`=bit 0, and `sel_q` otherwise.
  - Last flit: `cnt` reaches bit COUNT_0-1 (length 0) or bit COUNT_1-1 (length 1). On the last flit, `cnt <= 1` and `full <= 1`. Otherwise `cnt` rotates left by one.
- Word consume (`valid_out & ready_in`): `full <= 0`, unless a last flit is accepted in the same cycle, in which case `full` stays 1.
- Simultaneous consume and first-flit accept: the new flit overwrites slice 0 and clears the others. The old word has already been sampled downstream, so this is legal.
- Slices at index ≥ active count are always 0 in `parallel_out`.
- `count_sel` changes after the first flit of a word are ignored until the next word.
- COUNT_MAX==1:
  - Every flit is a last flit.
  - The block degenerates to a one-entry register slice with `cnt_out` = 1'b1.
- `parallel_out` is stable while `valid_out` is asserted and `ready_in` is low.

## Timing
- Reset values (async, while rst=0):
  - valid_out=0, ready_out=1
  - parallel_out=0, cnt_out=1 (one-hot bit 0)
  - `sel_q`=0, `full`=0
- Latency: valid_out rises the cycle after the last flit is accepted.
- Throughput: one flit per cycle sustained. With ready_in held high there is no bubble between words, i.e. one word every N cycles, N = active count.
- Backpressure: when FULL and ready_in=0, ready_out=0 and the block stalls. Partial words in COLLECT are held indefinitely while valid_in=0.
- Reset mid-word: the partial word is discarded, and the next accepted flit is flit 0 of a new word.

## Test plan
1. COUNT_0=2, COUNT_1=1, SER_WIDTH=8, ready_in=1, `count_sel`=0.
   - Stimulus: flits 0xA1, 0xB2.
   - Response: the cycle after 0xB2, valid_out=1 and parallel_out=0xB2A1. cnt_out sequence is 01, 10, 01.
2. Same config, `count_sel`=1, flit 0x5C.
   - Response: the next cycle, parallel_out=0x005C (upper slice zeroed) and valid_out=1.
3. Backpressure.
   - Stimulus: word 0x2211 done, ready_in=0 for 3 cycles, valid_in=1 with 0x33.
   - Response: ready_out=0 and parallel_out holds 0x2211 for those 3 cycles. After ready_in=1, 0x33 is accepted in the same cycle as the consume.
4. `count_sel` toggled after flit 0 of a 2-flit word.
   - Response: the word still completes after 2 flits, and `sel_q` remains 0.
5. Back-to-back traffic: ready_in=1, 6 flits continuous, alternating word lengths 2, 1, 2, 1.
   - Response: 4 words with no idle cycle on ready_out, and data matching the serializer input.
6. Reset mid-word.
   - Stimulus: assert rst=0 after flit 0 (0x77), then send 0x10, 0x20.
   - Response: valid_out=0 during reset, then word 0x2010 (0x77 lost).
